// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: widths and encodings shared by the memory unit and its RAM.
package mem_unit_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, WAIT_ST, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/ram_4k16.sv
// ram_4k16: 4096x16 single-port RAM with synchronous write and registered read.
module ram_4k16
  import mem_unit_pkg::*;
#(
  parameter int INIT_ZERO = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: (INIT_ZERO != 0) ? DATA_W'(0) : {DATA_W{1'bx}}};
  // CLR clears only the output register, never the array
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    if (CLR) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_unit.sv
// mem_unit: wait-stated memory access controller in front of a 4Kx16 RAM.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int WAIT      = 2,
  parameter int INIT_ZERO = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] AR,
  input  logic [DATA_W-1:0] memDIN,
  input  logic              memRD,
  input  logic              memWR,
  output logic [DATA_W-1:0] memDOUT,
  output logic              memBUSY,
  output logic              memRDY,
  output logic              memERR
);
  state_t state, nxt;
  op_t op;
  logic [2:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic [DATA_W-1:0] din_q;
  logic start, err_q, we, re;
  assign start = state == IDLE && (memRD ^ memWR);
  always_comb begin
    cnt_n = state == WAIT_ST ? cnt - 3'd1 : start ? 3'(WAIT) : cnt;
    nxt = state == DONE ? IDLE
        : state == WAIT_ST ? (cnt_n == 3'd0 ? DONE : WAIT_ST)
        : start ? (WAIT == 0 ? DONE : WAIT_ST) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      err_q <= state == IDLE && memRD && memWR;
      if (start) begin
        addr_q <= AR;
        din_q  <= memDIN;
        op     <= memWR ? OP_WR : OP_RD;
      end
    end
  end
  // reads are issued on the edge entering DONE so data lands with memRDY
  assign ram_addr = state == IDLE ? AR : addr_q;
  assign re = !CLR && nxt == DONE && (state == IDLE ? memRD : op == OP_RD);
  assign we = !CLR && state == DONE && op == OP_WR;
  ram_4k16 #(.INIT_ZERO(INIT_ZERO)) u_ram (
    .CLK(CLK),
    .CLR(CLR),
    .addr(ram_addr),
    .we(we),
    .re(re),
    .wdata(din_q),
    .rdata(memDOUT)
  );
  assign memBUSY = state != IDLE;
  assign memRDY  = state == DONE;
  assign memERR  = err_q;
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: two mem_unit instances (WAIT=2, WAIT=0) checked against a timing-based model.
module tb_mem_unit;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        clr [2];
  logic        rd  [2];
  logic        wr  [2];
  logic [11:0] ar  [2];
  logic [15:0] din [2];
  logic [15:0] dout [2];
  logic        busy [2];
  logic        rdy  [2];
  logic        err  [2];

  int total = 0;
  int bad = 0;

  mem_unit #(.WAIT(2), .INIT_ZERO(1)) dut0 (
    .CLK(CLK), .CLR(clr[0]), .AR(ar[0]), .memDIN(din[0]), .memRD(rd[0]), .memWR(wr[0]),
    .memDOUT(dout[0]), .memBUSY(busy[0]), .memRDY(rdy[0]), .memERR(err[0])
  );
  mem_unit #(.WAIT(0), .INIT_ZERO(1)) dut1 (
    .CLK(CLK), .CLR(clr[1]), .AR(ar[1]), .memDIN(din[1]), .memRD(rd[1]), .memWR(wr[1]),
    .memDOUT(dout[1]), .memBUSY(busy[1]), .memRDY(rdy[1]), .memERR(err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access sampled at edge n completes (memRDY) after edge n+WAIT,
  // the unit is idle again after edge n+WAIT+1, and a write lands at that edge.
  logic [15:0] m_mem [2][4096];
  logic        m_act [2];
  logic        m_wr  [2];
  logic        m_err [2];
  logic        m_live [2];
  logic [11:0] m_a   [2];
  logic [15:0] m_d   [2];
  logic [15:0] m_dout [2];
  int          m_done [2];
  int          n = 0;

  initial begin
    foreach (m_mem[d, a]) m_mem[d][a] = 16'h0000;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_err[d] = 0; m_live[d] = 0; m_dout[d] = 0; m_done[d] = 0;
      m_wr[d] = 0; m_a[d] = 0; m_d[d] = 0;
    end
  end

  always begin
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (clr[d]) begin
        m_act[d] = 0; m_dout[d] = 0; m_err[d] = 0; m_live[d] = 1;
      end else begin
        m_err[d] = 0;
        if (m_act[d] && n == m_done[d] + 1) begin
          if (m_wr[d]) m_mem[d][m_a[d]] = m_d[d];
          m_act[d] = 0;
        end else if (!m_act[d]) begin
          if (rd[d] && wr[d]) m_err[d] = 1;
          else if (rd[d] || wr[d]) begin
            m_act[d] = 1;
            m_done[d] = n + (d == 0 ? 2 : 0);
            m_wr[d] = wr[d]; m_a[d] = ar[d]; m_d[d] = din[d];
          end
        end
        if (m_act[d] && n == m_done[d] && !m_wr[d]) m_dout[d] = m_mem[d][m_a[d]];
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      if (m_live[d]) begin
        chk($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(m_act[d] && n == m_done[d]));
        chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_act[d]));
        chk($sformatf("err%0d", d), 32'(err[d]), 32'(m_err[d]));
        chk($sformatf("dout%0d", d), 32'(dout[d]), 32'(m_dout[d]));
      end
    end
    n++;
  end

  // Called at posedge+1 with the unit idle; returns cycles from request cycle to memRDY cycle.
  task automatic access(input int d, input bit w, input logic [11:0] a, input logic [15:0] v,
                        output int lat);
    rd[d] = !w; wr[d] = w; ar[d] = a; din[d] = v;
    @(posedge CLK); #1;
    rd[d] = 0; wr[d] = 0; ar[d] = 12'($urandom); din[d] = 16'($urandom);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (rdy[d]) lat = k;
      else begin @(posedge CLK); #1; end
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) begin @(posedge CLK); #1; end
  endtask

  int lat, cnt;

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1; rd[d] = 0; wr[d] = 0; ar[d] = 0; din[d] = 0;
    end
    idle(3);
    chk("rst_dout", 32'(dout[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_rdy", 32'(rdy[1]), 0);
    chk("rst_err", 32'(err[1]), 0);
    clr[0] = 0; clr[1] = 0;
    idle(1);

    access(0, 1, 12'h0A5, 16'hBEEF, lat); chk("wr_lat", 32'(lat), 3);
    access(0, 0, 12'h0A5, 16'h0000, lat); chk("rd_lat", 32'(lat), 3);
    chk("rd_beef", 32'(dout[0]), 32'h0000BEEF);

    access(0, 1, 12'hFFF, 16'h1234, lat);
    access(0, 1, 12'h000, 16'h5678, lat);
    access(0, 0, 12'hFFF, 16'h0000, lat); chk("rd_fff", 32'(dout[0]), 32'h1234);
    access(0, 0, 12'h000, 16'h0000, lat); chk("rd_000", 32'(dout[0]), 32'h5678);

    rd[0] = 1; wr[0] = 1; ar[0] = 12'h0A5; din[0] = 16'h0BAD;
    @(posedge CLK); #1;
    chk("both_err", 32'(err[0]), 1);
    chk("both_busy", 32'(busy[0]), 0);
    rd[0] = 0; wr[0] = 0;
    @(posedge CLK); #1;
    chk("err_pulse", 32'(err[0]), 0);
    access(0, 0, 12'h0A5, 16'h0000, lat); chk("both_nochg", 32'(dout[0]), 32'hBEEF);

    access(0, 1, 12'h010, 16'h5A5A, lat);
    wr[0] = 1; ar[0] = 12'h010; din[0] = 16'hAAAA;
    @(posedge CLK); #1;
    wr[0] = 0; clr[0] = 1;
    chk("abort_nordy", 32'(rdy[0]), 0);
    @(posedge CLK); #1;
    clr[0] = 0;
    chk("abort_busy", 32'(busy[0]), 0);
    idle(3);
    access(0, 0, 12'h010, 16'h0000, lat); chk("abort_keep", 32'(dout[0]), 32'h5A5A);

    wr[0] = 1; ar[0] = 12'h020; din[0] = 16'h7777;
    @(posedge CLK); #1;
    ar[0] = 12'h021; din[0] = 16'h8888;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      wr[0] = 0;
      cnt += int'(rdy[0]);
    end
    chk("busy_wr_rdys", 32'(cnt), 1);
    access(0, 0, 12'h021, 16'h0000, lat); chk("busy_wr_ign", 32'(dout[0]), 0);
    access(0, 0, 12'h020, 16'h0000, lat); chk("busy_wr_ok", 32'(dout[0]), 32'h7777);

    for (int i = 0; i < 8; i++) begin
      access(1, 1, 12'(i), 16'h1000 + 16'(i), lat);
      if (i == 0) chk("w0_lat", 32'(lat), 1);
    end
    rd[1] = 1; ar[1] = 12'h000;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (i == 0) chk("w0_first", 32'(dout[1]), 32'h1000);
      cnt += int'(rdy[1]);
      ar[1] = 12'($urandom_range(0, 7));
    end
    chk("w0_rdy_cnt", 32'(cnt), 10);
    rd[1] = 0;
    idle(2);

    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        int r;
        r = $urandom_range(0, 9);
        clr[d] = $urandom_range(0, 99) == 0;
        rd[d] = r < 3 || r == 9;
        wr[d] = (r >= 3 && r < 6) || r == 9;
        ar[d] = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
        din[d] = 16'($urandom);
      end
      @(posedge CLK); #1;
    end
    for (int d = 0; d < 2; d++) begin rd[d] = 0; wr[d] = 0; clr[d] = 0; end
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
